gearbox_rx: RTL and testbench
=============================

# gearbox_rx

Receive-side 64b/66b gearbox for the PCS. It takes the continuous 64-bit word stream from the PMA/deserializer and re-frames it into 66-bit blocks (2-bit sync header plus 64-bit payload) for the descrambler and decoder. A `slip_i` input discards one stream bit so the upstream block-lock state machine can step through all 66 alignments. Bit ordering matches the transmit gearbox: the earliest bit is at the LSB, and the header occupies the block LSBs, i.e. block = {data, head}.

## Interface
- `DATA_W`, default 64: payload and input word width; only 64 is supported.
- `HEAD_W`, default 2: sync header width; only 2 is supported. `BLOCK_W` = `HEAD_W` + `DATA_W` = 66 is derived locally.

Ports:
- `clk`  in  1: single clock; all state on its rising edge.
- `nreset`  in  1: reset, asynchronous, active-low.
- `data_i`  in  `DATA_W`: PMA word; one valid word is presented every cycle, with no valid qualifier.
- `slip_i`  in  1: drop the oldest buffered bit this cycle (1-cycle pulse; level means one slip per cycle).
- `valid_o`  out  1: `head_o`/`data_o` carry a new block this cycle.
- `head_o`  out  `HEAD_W`: sync header of the block (stream bits 0..1 of the block).
- `data_o`  out  `DATA_W`: payload of the block (stream bits 2..65 of the block).

## Operation
- State: `buf_q` [64:0] holds residual unconsumed bits, LSB oldest; `cnt_q` [6:0] counts valid residual bits, range 0..65.
- Each cycle, form the window `win` = (`buf_q` masked to `cnt_q` bits) | (`data_i` << `cnt_q`). The window is 129 bits, and `avail` = `cnt_q` + 64.
- Slip: `s` = `slip_i`; `eff` = `avail` − `s`; extraction starts at window bit `s`.
- If `eff` >= 66:
  - block = `win`[`s` +: 66]; `head_o` <= block[1:0]; `data_o` <= block[65:2]; `valid_o` <= 1.
  - `buf_q` <= `win` >> (`s`+66); `cnt_q` <= `eff` − 66.
- Else:
  - `valid_o` <= 0; `head_o`/`data_o` hold their previous values.
  - `buf_q` <= `win` >> `s`; `cnt_q` <= `eff`.
- Invariant: `cnt_q` <= 65 always. Bits of `buf_q` above `cnt_q` are don't-care but must not reach outputs, so masking is mandatory.
- No slip, from reset, `cnt_q` sequence is 0, 64, 62, 60, ..., 2, 0: one non-valid cycle per 33 input words and 32 blocks per 33 words, mirroring TX backpressure.
- Each slip permanently advances alignment by one bit. 66 slips return to the original alignment, shifted by one block.
- Slip on a non-valid cycle when `avail` = 64 gives `cnt_q` = 63; legal.
- The block performs no header checking. Header validity and lock are owned downstream.

## Timing
- Reset values: `valid_o` = 0, `head_o` = 0, `data_o` = 0, `cnt_q` = 0, `buf_q` = 0. Reset takes effect immediately (asynchronous); deassertion is synchronised by the user.
- All outputs are registered. A block completed by the word sampled at edge N is on outputs after edge N; latency is one cycle from the completing word.
- The first word after reset never produces a block. The first `valid_o` follows the second sampled word.
- `slip_i` is sampled on the same edge as `data_i`. Its effect is visible in the block emitted on that edge if one is emitted.
- Reset asserted mid-stream discards residual bits. After release, framing restarts from the next sampled word as bit 0.

## Test plan
- Aligned stream: pack 32 blocks with head 2'b11 for block 0 and 2'b10 thereafter, data 64'hfedcba9876543210, into 33 words. Word 0 = {64'hfedcba9876543210[61:0], 2'b11}. Drive after reset -> `valid_o` low on word 0 and high on words 1..32; every `data_o` = 64'hfedcba9876543210; `head_o` = 2'b11 for block 0, then 2'b10; `cnt_q` = 0 after word 32.
- Continuous stream of 330 words (320 blocks, random data) -> exactly one `valid_o`=0 cycle every 33 cycles; all blocks match the reference model; no X on outputs while `nreset`=1.
- Stream pre-shifted by 5 bits (5 garbage bits prepended); pulse `slip_i` on 5 distinct early cycles -> every later block matches, with head in {01,10}.
- 66 consecutive `slip_i` cycles on an aligned stream -> after recovery, output resumes aligned, with exactly one block lost relative to no-slip.
- Slip on the non-valid cycle (`cnt_q` = 0, `avail` = 64) -> `cnt_q` = 63 next; next block equals the stream block starting 1 bit later.
- Assert `nreset` at block 17 -> outputs 0 immediately. After release, the re-sent aligned stream reproduces the first scenario exactly.

Source files
------------

// File: rtl/gearbox_rx_if.sv
// Purpose: PMA word stream into the RX gearbox and 66-bit blocks out of it.
// Latency: n/a (signal bundle only).
// Backpressure: none; one word per cycle in, blocks qualified by valid_o.
interface gearbox_rx_if #(
  parameter int DATA_W = 64,
  parameter int HEAD_W = 2
);
  logic [DATA_W-1:0] data_i;
  logic              slip_i;
  logic              valid_o;
  logic [HEAD_W-1:0] head_o;
  logic [DATA_W-1:0] data_o;

  // PMA / block-lock side: supplies words and slip requests, consumes blocks.
  modport master (output data_i, slip_i, input valid_o, head_o, data_o);
  // Gearbox side.
  modport slave  (input data_i, slip_i, output valid_o, head_o, data_o);
endinterface

// File: rtl/gearbox_rx.sv
// Purpose: re-frame a continuous 64-bit PMA stream into 66-bit {data, head} blocks, with bit slip.
// Latency: 1 cycle from the word that completes a block to valid_o/head_o/data_o.
// Backpressure: none; valid_o drops one cycle in 33 when fewer than 66 bits are buffered.
module gearbox_rx #(
  parameter int DATA_W = 64,
  parameter int HEAD_W = 2
) (
  input  logic        clk,
  input  logic        nreset,
  gearbox_rx_if.slave bus
);
  localparam int BLOCK_W = HEAD_W + DATA_W;  // 66
  localparam int BUF_W   = BLOCK_W - 1;      // residual never exceeds 65 bits
  localparam int WIN_W   = BUF_W + DATA_W;   // residual plus one incoming word
  localparam int CNT_W   = 7;
  localparam int AVL_W   = 8;

  logic [BUF_W-1:0]   buf_q;
  logic [BUF_W-1:0]   buf_n;
  logic [BUF_W-1:0]   buf_mask;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_n;
  logic [WIN_W-1:0]   win;
  logic [WIN_W-1:0]   win_s;
  logic [AVL_W-1:0]   avail;
  logic [AVL_W-1:0]   eff;
  logic               emit;
  logic [BLOCK_W-1:0] blk;
  logic               valid_q;
  logic [HEAD_W-1:0]  head_q;
  logic [DATA_W-1:0]  data_q;

  // Build the bit window, apply the slip and decide whether a whole block is available.
  always_comb begin
    // Stale bits above cnt_q must never leak into the window, so mask them off.
    buf_mask = ~({BUF_W{1'b1}} << cnt_q);
    win      = {{DATA_W{1'b0}}, buf_q & buf_mask}
             | ({{BUF_W{1'b0}}, bus.data_i} << cnt_q);
    avail    = AVL_W'(cnt_q) + AVL_W'(DATA_W);
    eff      = avail - AVL_W'(bus.slip_i);
    emit     = (eff >= AVL_W'(BLOCK_W));
    // A slip drops the oldest bit, i.e. the first bit of the next block.
    win_s    = win >> bus.slip_i;
    blk      = BLOCK_W'(win_s);
    buf_n    = emit ? BUF_W'(win_s >> BLOCK_W) : BUF_W'(win_s);
    cnt_n    = emit ? CNT_W'(eff - AVL_W'(BLOCK_W)) : CNT_W'(eff);
  end

  // Residual buffer and registered block outputs; outputs hold on non-valid cycles.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      buf_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      head_q  <= '0;
      data_q  <= '0;
    end else begin
      buf_q   <= buf_n;
      cnt_q   <= cnt_n;
      valid_q <= emit;
      if (emit) begin
        head_q <= blk[HEAD_W-1:0];
        data_q <= blk[BLOCK_W-1:HEAD_W];
      end
    end
  end

  assign bus.valid_o = valid_q;
  assign bus.head_o  = head_q;
  assign bus.data_o  = data_q;
endmodule

// File: tb/tb_gearbox_rx.sv
// Purpose: directed bench for gearbox_rx: framing, slip, reset behaviour.
// Latency: checks outputs 1 time unit after the edge that sampled each word.
// Backpressure: none; one word driven per cycle.
module tb_gearbox_rx;
  localparam logic [63:0] PAY = 64'hfedcba9876543210;

  logic clk = 1'b0;
  logic nreset;
  gearbox_rx_if #(.DATA_W(64), .HEAD_W(2)) bus ();
  gearbox_rx #(.DATA_W(64), .HEAD_W(2)) dut (.clk(clk), .nreset(nreset), .bus(bus));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Transmit-side bit stream (LSB first) and read pointer.
  bit txb[$];
  int txp;
  // Receive-side reference: a plain bit FIFO.
  bit rxq[$];
  logic        exp_vld;
  logic [65:0] exp_blk;

  task automatic tx_clear();
    txb.delete();
    txp = 0;
  endtask

  task automatic tx_push_block(input logic [1:0] h, input logic [63:0] d);
    logic [65:0] b;
    b = {d, h};
    for (int i = 0; i < 66; i++) txb.push_back(b[i]);
  endtask

  task automatic tx_next(output logic [63:0] w);
    for (int i = 0; i < 64; i++) w[i] = (txp + i < txb.size()) ? txb[txp + i] : 1'b0;
    txp += 64;
  endtask

  function automatic logic [65:0] tx_bits(input int pos);
    logic [65:0] b;
    for (int i = 0; i < 66; i++) b[i] = txb[pos + i];
    return b;
  endfunction

  task automatic rand_blocks(input int n);
    logic [1:0] h;
    for (int i = 0; i < n; i++) begin
      h = ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b10;
      tx_push_block(h, {$urandom, $urandom});
    end
  endtask

  // Drive one word away from the edge, let it be sampled, then advance the reference.
  task automatic cycle(input logic [63:0] w, input logic s);
    bus.data_i = w;
    bus.slip_i = s;
    @(posedge clk);
    #1;
    for (int i = 0; i < 64; i++) rxq.push_back(w[i]);
    if (s) void'(rxq.pop_front());
    if (rxq.size() >= 66) begin
      exp_vld = 1'b1;
      for (int i = 0; i < 66; i++) exp_blk[i] = rxq.pop_front();
    end else begin
      exp_vld = 1'b0;
    end
  endtask

  task automatic apply_reset();
    nreset     = 1'b0;
    bus.data_i = '0;
    bus.slip_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    nreset = 1'b1;
    rxq.delete();
  endtask

  task automatic test_reset();
    nreset     = 1'b1;
    bus.data_i = '0;
    bus.slip_i = 1'b0;
    #2 nreset = 1'b0;
    #1;
    n_checks++;
    if (bus.valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b want=0", bus.valid_o); end
    n_checks++;
    if (bus.head_o !== 2'b00) begin n_fail++; $display("FAIL reset_head got=%b want=00", bus.head_o); end
    n_checks++;
    if (bus.data_o !== 64'd0) begin n_fail++; $display("FAIL reset_data got=%h want=0", bus.data_o); end
    n_checks++;
    if (dut.cnt_q !== 7'd0) begin n_fail++; $display("FAIL reset_cnt got=%0d want=0", dut.cnt_q); end
    n_checks++;
    if (dut.buf_q !== 65'd0) begin n_fail++; $display("FAIL reset_buf got=%h want=0", dut.buf_q); end
  endtask

  task automatic test_aligned(input bit do_reset);
    logic [63:0] w;
    logic [1:0]  eh;
    if (do_reset) apply_reset();
    tx_clear();
    tx_push_block(2'b11, PAY);
    for (int i = 1; i < 32; i++) tx_push_block(2'b10, PAY);
    for (int k = 0; k < 33; k++) begin
      tx_next(w);
      cycle(w, 1'b0);
      n_checks++;
      if (dut.cnt_q !== 7'(64 - 2 * k)) begin
        n_fail++; $display("FAIL aligned_cnt word=%0d got=%0d want=%0d", k, dut.cnt_q, 64 - 2 * k);
      end
      if (k == 0) begin
        n_checks++;
        if (bus.valid_o !== 1'b0 || bus.data_o !== 64'd0) begin
          n_fail++; $display("FAIL aligned_first valid=%b data=%h want valid=0 data=0", bus.valid_o, bus.data_o);
        end
      end else begin
        eh = (k == 1) ? 2'b11 : 2'b10;
        n_checks++;
        if (bus.valid_o !== 1'b1 || bus.data_o !== PAY || bus.head_o !== eh) begin
          n_fail++;
          $display("FAIL aligned_blk word=%0d valid=%b head=%b data=%h want valid=1 head=%b data=%h",
                   k, bus.valid_o, bus.head_o, bus.data_o, eh, PAY);
        end
      end
    end
  endtask

  task automatic test_stream_random();
    logic [63:0] w;
    int gaps;
    apply_reset();
    gaps = 0;
    for (int k = 0; k < 330; k++) begin
      w = {$urandom, $urandom};
      cycle(w, 1'b0);
      n_checks++;
      if ($isunknown({bus.valid_o, bus.head_o, bus.data_o})) begin
        n_fail++; $display("FAIL stream_x word=%0d valid=%b head=%b data=%h", k, bus.valid_o, bus.head_o, bus.data_o);
      end
      n_checks++;
      if (bus.valid_o !== (k % 33 != 0)) begin
        n_fail++; $display("FAIL stream_valid word=%0d got=%b want=%b", k, bus.valid_o, (k % 33 != 0));
      end
      if (exp_vld) begin
        n_checks++;
        if ({bus.data_o, bus.head_o} !== exp_blk) begin
          n_fail++; $display("FAIL stream_blk word=%0d got=%h want=%h", k, {bus.data_o, bus.head_o}, exp_blk);
        end
      end
      if (bus.valid_o !== 1'b1) gaps++;
    end
    n_checks++;
    if (gaps != 10) begin n_fail++; $display("FAIL stream_gaps got=%0d want=10", gaps); end
  endtask

  task automatic test_preshift();
    logic [63:0] w;
    logic [31:0] r;
    logic        s;
    int          nv;
    apply_reset();
    tx_clear();
    for (int i = 0; i < 5; i++) begin
      r = $urandom;
      txb.push_back(r[0]);
    end
    rand_blocks(44);
    nv = 0;
    for (int k = 0; k < 40; k++) begin
      tx_next(w);
      s = (k == 2 || k == 4 || k == 6 || k == 8 || k == 10);
      cycle(w, s);
      n_checks++;
      if (bus.valid_o !== exp_vld) begin
        n_fail++; $display("FAIL preshift_valid word=%0d got=%b want=%b", k, bus.valid_o, exp_vld);
      end
      if (exp_vld) begin
        // Five slips absorb the five prepended bits: block nv now starts at tx bit 5+66*nv.
        if (k >= 10) begin
          n_checks++;
          if ({bus.data_o, bus.head_o} !== tx_bits(5 + 66 * nv)) begin
            n_fail++; $display("FAIL preshift_blk word=%0d got=%h want=%h", k, {bus.data_o, bus.head_o}, tx_bits(5 + 66 * nv));
          end
          n_checks++;
          if (bus.head_o !== 2'b01 && bus.head_o !== 2'b10) begin
            n_fail++; $display("FAIL preshift_head word=%0d got=%b want=01|10", k, bus.head_o);
          end
        end
        nv++;
      end
    end
  endtask

  task automatic test_slip66();
    logic [63:0] w;
    logic        s;
    int          nv;
    apply_reset();
    tx_clear();
    rand_blocks(90);
    nv = 0;
    for (int k = 0; k < 90; k++) begin
      tx_next(w);
      s = (k >= 3 && k < 69);
      cycle(w, s);
      n_checks++;
      if (bus.valid_o !== exp_vld) begin
        n_fail++; $display("FAIL slip66_valid word=%0d got=%b want=%b", k, bus.valid_o, exp_vld);
      end
      if (exp_vld) begin
        n_checks++;
        if ({bus.data_o, bus.head_o} !== exp_blk) begin
          n_fail++; $display("FAIL slip66_model word=%0d got=%h want=%h", k, {bus.data_o, bus.head_o}, exp_blk);
        end
        // After 66 slips the framing is aligned again but one block later.
        if (k >= 69) begin
          n_checks++;
          if ({bus.data_o, bus.head_o} !== tx_bits(66 * (nv + 1))) begin
            n_fail++; $display("FAIL slip66_blk word=%0d got=%h want=%h", k, {bus.data_o, bus.head_o}, tx_bits(66 * (nv + 1)));
          end
        end
        nv++;
      end
    end
  endtask

  task automatic test_slip_invalid();
    logic [63:0] w;
    apply_reset();
    tx_clear();
    rand_blocks(34);
    for (int k = 0; k < 33; k++) begin
      tx_next(w);
      cycle(w, 1'b0);
    end
    tx_next(w);
    cycle(w, 1'b1);
    n_checks++;
    if (bus.valid_o !== 1'b0) begin n_fail++; $display("FAIL slipinv_valid0 got=%b want=0", bus.valid_o); end
    n_checks++;
    if (dut.cnt_q !== 7'd63) begin n_fail++; $display("FAIL slipinv_cnt got=%0d want=63", dut.cnt_q); end
    n_checks++;
    if ({bus.data_o, bus.head_o} !== tx_bits(66 * 31)) begin
      n_fail++; $display("FAIL slipinv_hold got=%h want=%h", {bus.data_o, bus.head_o}, tx_bits(66 * 31));
    end
    tx_next(w);
    cycle(w, 1'b0);
    n_checks++;
    if (bus.valid_o !== 1'b1) begin n_fail++; $display("FAIL slipinv_valid1 got=%b want=1", bus.valid_o); end
    n_checks++;
    if ({bus.data_o, bus.head_o} !== tx_bits(66 * 32 + 1)) begin
      n_fail++; $display("FAIL slipinv_blk got=%h want=%h", {bus.data_o, bus.head_o}, tx_bits(66 * 32 + 1));
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] w;
    apply_reset();
    tx_clear();
    tx_push_block(2'b11, PAY);
    for (int i = 1; i < 32; i++) tx_push_block(2'b10, PAY);
    for (int k = 0; k < 18; k++) begin
      tx_next(w);
      cycle(w, 1'b0);
    end
    n_checks++;
    if (bus.valid_o !== 1'b1 || bus.head_o !== 2'b10 || bus.data_o !== PAY) begin
      n_fail++; $display("FAIL midrst_blk17 valid=%b head=%b data=%h want valid=1 head=10 data=%h",
                         bus.valid_o, bus.head_o, bus.data_o, PAY);
    end
    #2 nreset = 1'b0;
    #1;
    n_checks++;
    if (bus.valid_o !== 1'b0 || bus.head_o !== 2'b00 || bus.data_o !== 64'd0) begin
      n_fail++; $display("FAIL midrst_out valid=%b head=%b data=%h want all 0", bus.valid_o, bus.head_o, bus.data_o);
    end
    n_checks++;
    if (dut.cnt_q !== 7'd0) begin n_fail++; $display("FAIL midrst_cnt got=%0d want=0", dut.cnt_q); end
    @(negedge clk);
    nreset = 1'b1;
    rxq.delete();
    test_aligned(1'b0);
  endtask

  initial begin
    test_reset();
    test_aligned(1'b1);
    test_stream_random();
    test_preshift();
    test_slip66();
    test_slip_invalid();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end
endmodule
